ifetch_queue: RTL and testbench
===============================

Name: ifetch_queue

Overview:
- Parametrised successor to the core's single-instruction fetch path.
- Runs ahead of execute: issues sequential instruction fetches on the ibus and buffers up to DEPTH returned {pc, instr} pairs in a FIFO.
- Execute consumes pairs with a valid/ready handshake.
- A redirect from branch/jump resolution flushes the buffer and any in-flight fetch, and restarts fetching at the new PC.

Parameters:
- DEPTH, 4, FIFO entries; power of two, range 2..16.
- ADDR_W, 64, PC and bus address width.
- INSTR_W, 32, instruction width.
- RESET_PC, 64'h0000_0000_8000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- ireq_valid  out  1  fetch request valid (maps to ibus_req_t.valid).
- ireq_addr  out  ADDR_W  fetch address (maps to ibus_req_t.addr).
- iresp_addr_ok  in  1  bus accepted the address.
- iresp_data_ok  in  1  bus returns data this cycle.
- iresp_data  in  INSTR_W  returned instruction.
- redirect_valid  in  1  flush and restart request.
- redirect_pc  in  ADDR_W  restart address; bit[1:0] forced to 0.
- out_valid  out  1  FIFO head valid.
- out_pc  out  ADDR_W  PC of head instruction.
- out_instr  out  INSTR_W  head instruction.
- out_ready  in  1  consumer takes head.
- occupancy  out  $clog2(DEPTH)+1  entries currently held.

Behaviour:
- Reset (asynchronous, any time, including mid-transaction):
  - fetch_pc=RESET_PC; FIFO empty; state=IDLE; drop flag=0.
  - Outputs: ireq_valid=0, ireq_addr=0, out_valid=0, out_pc=0, out_instr=0, occupancy=0.
- Bus rules:
  - At most one outstanding fetch.
  - Once ireq_valid rises, ireq_valid and ireq_addr stay stable until the cycle iresp_addr_ok=1.
  - data_ok may arrive in the same cycle as addr_ok or any later cycle.
- State machine:
  - IDLE: if (occupancy + 0) < DEPTH and no redirect this cycle, go to REQ next cycle. req_addr <= fetch_pc; ireq_valid registered high in REQ.
  - REQ: ireq_valid=1, ireq_addr=req_addr.
    - On addr_ok, fetch_pc <= req_addr+4.
    - addr_ok with data_ok in the same cycle -> IDLE.
    - addr_ok without data_ok -> WAIT.
  - WAIT: ireq_valid=0; on data_ok -> IDLE.
- Credit rule:
  - IDLE issues only if occupancy < DEPTH, counting a pop in the same cycle as freeing a slot.
  - A returned instruction therefore always has a free slot; no overflow is possible.
- Push: on data_ok with drop=0, enqueue {req_addr, iresp_data}.
- Pop: out_valid & out_ready dequeues the head. Push and pop in the same cycle leave occupancy unchanged.
- FIFO:
  - Head/tail pointers wrap modulo DEPTH.
  - out_* driven combinationally from the head entry; out_pc/out_instr read 0 when empty.
- Redirect (redirect_valid=1), takes priority over everything else this cycle:
  - FIFO cleared next cycle; a same-cycle pop or push is ignored.
  - fetch_pc <= {redirect_pc[ADDR_W-1:2], 2'b00}.
  - In IDLE: no request issued this cycle; REQ for the new PC begins the next cycle.
  - In REQ: the request is held until addr_ok (bus rule), drop is set, and fetch_pc is not overwritten by the addr_ok increment.
  - In WAIT: drop is set.
  - data_ok in the same cycle as the redirect: that data is dropped.
- Drop flag: while drop=1, the next data_ok is discarded, not pushed, and clears drop. The FSM then returns to IDLE and fetches from the redirected fetch_pc.
- Back-to-back redirects: the last one wins; drop stays set; only one response is discarded.
- Throughput: one instruction per 2 cycles with single-cycle bus (IDLE/REQ alternation). Ahead-of-execute prefetch hides multi-cycle bus latency up to DEPTH.

Test Plan:
- Reset, bus with addr_ok and data_ok in same cycle, out_ready=1 -> out_pc sequence 0x80000000, 0x80000004, 0x80000008 with matching instrs; occupancy never exceeds 1.
- out_ready=0, DEPTH=4 -> exactly 4 fetches issued (0x80000000..0x8000000C); ireq_valid stays 0 while occupancy=4.
- Raise out_ready for one cycle at occupancy=4 -> the next fetch is at 0x80000010.
- Bus data_ok delayed 3 cycles after addr_ok; redirect_valid with redirect_pc=0x80001002 during WAIT -> the pending response is discarded, FIFO empty. Next request addr is 0x80001000, and the first out_pc is 0x80001000.
- Redirect in REQ with addr_ok withheld 2 cycles -> ireq_addr holds the old address until addr_ok; that response is dropped; next ireq_addr is the redirect PC.
- Redirect in the same cycle as data_ok and pop at occupancy=2 -> occupancy=0 next cycle and the data is not enqueued.
- reset asserted in WAIT -> all outputs 0 immediately (asynchronous); after release, first ireq_addr=RESET_PC; a stale data_ok arriving after reset is ignored.

Source files
------------

// File: rtl/ifetch_queue.sv
// ifetch_queue: sequential instruction prefetcher that keeps a DEPTH-entry
// FIFO of {pc, instr} pairs ahead of execute and flushes on redirect.
module ifetch_queue #(
  parameter int                DEPTH    = 4,
  parameter int                ADDR_W   = 64,
  parameter int                INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   ireq_valid,
  output logic [ADDR_W-1:0]      ireq_addr,
  input  logic                   iresp_addr_ok,
  input  logic                   iresp_data_ok,
  input  logic [INSTR_W-1:0]     iresp_data,
  input  logic                   redirect_valid,
  input  logic [ADDR_W-1:0]      redirect_pc,
  output logic                   out_valid,
  output logic [ADDR_W-1:0]      out_pc,
  output logic [INSTR_W-1:0]     out_instr,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   fetch_pc;
  logic [ADDR_W-1:0]   req_addr;
  logic                drop;

  logic [ADDR_W-1:0]   pc_mem    [DEPTH];
  logic [INSTR_W-1:0]  instr_mem [DEPTH];
  logic [PTR_W-1:0]    head_ptr;
  logic [PTR_W-1:0]    tail_ptr;
  logic [CNT_W-1:0]    count;

  logic                resp;
  logic                push;
  logic                pop;
  logic                has_credit;
  logic [ADDR_W-1:0]   redirect_aligned;

  // A response completes either together with the address handshake or later in WAIT;
  // data_ok seen in IDLE belongs to no request of ours and is ignored.
  assign resp = ((state == S_REQ) && iresp_addr_ok && iresp_data_ok) ||
                ((state == S_WAIT) && iresp_data_ok);
  assign push = resp && !drop && !redirect_valid;
  assign pop  = out_valid && out_ready && !redirect_valid;

  // A same-cycle pop frees a slot, so the single outstanding fetch always lands somewhere.
  assign has_credit = (count < DEPTH_CNT) || pop;

  assign redirect_aligned = redirect_pc & ~ADDR_W'(3);

  assign ireq_addr = req_addr;
  assign occupancy = count;
  assign out_valid = (count != '0);
  assign out_pc    = out_valid ? pc_mem[head_ptr]    : '0;
  assign out_instr = out_valid ? instr_mem[head_ptr] : '0;

  // Fetch FSM: issues one request at a time, tracks the next sequential PC and the drop flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      fetch_pc   <= RESET_PC;
      req_addr   <= '0;
      drop       <= 1'b0;
      ireq_valid <= 1'b0;
    end else begin
      if (redirect_valid) begin
        fetch_pc <= redirect_aligned;
      end else if ((state == S_REQ) && iresp_addr_ok && !drop) begin
        fetch_pc <= req_addr + ADDR_W'(4);
      end

      if (resp) begin
        drop <= 1'b0;
      end else if (redirect_valid && (state != S_IDLE)) begin
        drop <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (!redirect_valid && has_credit) begin
            state      <= S_REQ;
            req_addr   <= fetch_pc;
            ireq_valid <= 1'b1;
          end
        end
        S_REQ: begin
          if (iresp_addr_ok) begin
            ireq_valid <= 1'b0;
            state      <= iresp_data_ok ? S_IDLE : S_WAIT;
          end
        end
        S_WAIT: begin
          if (iresp_data_ok) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state      <= S_IDLE;
          ireq_valid <= 1'b0;
        end
      endcase
    end
  end

  // FIFO bookkeeping: pointers wrap naturally since DEPTH is a power of two; redirect empties it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else if (redirect_valid) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        tail_ptr <= tail_ptr + 1'b1;
      end
      if (pop) begin
        head_ptr <= head_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  // Storage array: written on accepted responses only; the head is read combinationally.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[tail_ptr]    <= req_addr;
      instr_mem[tail_ptr] <= iresp_data;
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: bus responder model plus scoreboard of expected {pc, instr}
// pairs, with a cycle table for fill/credit and hand sequences for flush corners.
module tb_ifetch_queue;

  localparam int          DEPTH    = 4;
  localparam int          ADDR_W   = 64;
  localparam int          INSTR_W  = 32;
  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

  logic               clk;
  logic               reset;
  logic               ireq_valid;
  logic [ADDR_W-1:0]  ireq_addr;
  logic               iresp_addr_ok;
  logic               iresp_data_ok;
  logic [INSTR_W-1:0] iresp_data;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               out_valid;
  logic [ADDR_W-1:0]  out_pc;
  logic [INSTR_W-1:0] out_instr;
  logic               out_ready;
  logic [2:0]         occupancy;

  ifetch_queue #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk), .reset(reset),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
    .iresp_addr_ok(iresp_addr_ok), .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
    .out_ready(out_ready), .occupancy(occupancy)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } exp_t;

  typedef struct {
    logic        ready;
    logic        exp_ivalid;
    logic [63:0] exp_addr;
    logic [2:0]  exp_occ;
  } vec_t;

  exp_t        exp_q[$];
  vec_t        vecs[15];
  int          checks;
  int          errors;
  int          addr_delay;
  int          data_delay;
  int          addr_cnt;
  int          data_cnt;
  int          accept_count;
  int          pops;
  logic        bus_waiting;
  logic        tb_drop;
  logic        force_stale;
  logic [63:0] bus_addr;
  logic [63:0] last_accept;
  logic [63:0] last_pop_pc;

  function automatic logic [31:0] instr_of(input logic [63:0] addr);
    return addr[31:0] ^ 32'h1357_9BDF;
  endfunction

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // One clock cycle: compare any pop against the scoreboard, play the bus, then advance.
  task automatic apply_stimulus();
    bit   delivered;
    exp_t e;
    delivered     = 1'b0;
    iresp_addr_ok = 1'b0;
    iresp_data_ok = 1'b0;
    iresp_data    = '0;
    if (out_valid && out_ready && !redirect_valid) begin
      pops++;
      last_pop_pc = out_pc;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL pop_unexpected: got pc %h, expected no entry", out_pc);
      end else begin
        e = exp_q.pop_front();
        check_output("pop_pc", out_pc, e.pc);
        check_output("pop_instr", 64'(out_instr), 64'(e.instr));
      end
    end
    if (bus_waiting) begin
      if (data_cnt <= 1) delivered = 1'b1;
      else data_cnt--;
    end else if (ireq_valid) begin
      if (addr_cnt >= addr_delay) begin
        iresp_addr_ok = 1'b1;
        bus_addr      = ireq_addr;
        last_accept   = ireq_addr;
        accept_count++;
        addr_cnt      = 0;
        if (data_delay == 0) begin
          delivered = 1'b1;
        end else begin
          bus_waiting = 1'b1;
          data_cnt    = data_delay;
        end
      end else begin
        addr_cnt++;
      end
    end
    if (delivered) begin
      bus_waiting   = 1'b0;
      iresp_data_ok = 1'b1;
      iresp_data    = instr_of(bus_addr);
      if (tb_drop || redirect_valid) begin
        tb_drop = 1'b0;
      end else begin
        e.pc    = bus_addr;
        e.instr = instr_of(bus_addr);
        exp_q.push_back(e);
      end
    end else if (force_stale) begin
      iresp_data_ok = 1'b1;
      iresp_data    = 32'hDEAD_BEEF;
    end
    if (redirect_valid) begin
      exp_q.delete();
      if (!delivered && (bus_waiting || ireq_valid)) tb_drop = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b0;
    force_stale    = 1'b0;
    iresp_addr_ok  = 1'b0;
    iresp_data_ok  = 1'b0;
    iresp_data     = '0;
    bus_waiting    = 1'b0;
    tb_drop        = 1'b0;
    addr_cnt       = 0;
    data_cnt       = 0;
    accept_count   = 0;
    pops           = 0;
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_accept(input string name, input logic [63:0] exp_addr);
    int start;
    bit seen;
    start = accept_count;
    seen  = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      apply_stimulus();
      if (accept_count > start) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: got no request within 20 cycles, expected addr %h", name, exp_addr);
    end else begin
      check_output(name, last_accept, exp_addr);
    end
  endtask

  task automatic wait_pop(input string name, input logic [63:0] exp_pc);
    int start;
    bit seen;
    start = pops;
    seen  = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      apply_stimulus();
      if (pops > start) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: got no output within 20 cycles, expected pc %h", name, exp_pc);
    end else begin
      check_output(name, last_pop_pc, exp_pc);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_ireq_valid"}, 64'(ireq_valid), 64'd0);
    check_output({tag, "_ireq_addr"},  ireq_addr,       64'd0);
    check_output({tag, "_out_valid"},  64'(out_valid),  64'd0);
    check_output({tag, "_out_pc"},     out_pc,          64'd0);
    check_output({tag, "_out_instr"},  64'(out_instr),  64'd0);
    check_output({tag, "_occupancy"},  64'(occupancy),  64'd0);
  endtask

  // Test sequence: table-driven fill/credit, streaming, then redirect and reset corners.
  initial begin
    checks     = 0;
    errors     = 0;
    addr_delay = 0;
    data_delay = 0;
    vecs[0]  = '{1'b0, 1'b0, 64'h0,         3'd0};
    vecs[1]  = '{1'b0, 1'b1, 64'h8000_0000, 3'd0};
    vecs[2]  = '{1'b0, 1'b0, 64'h0,         3'd1};
    vecs[3]  = '{1'b0, 1'b1, 64'h8000_0004, 3'd1};
    vecs[4]  = '{1'b0, 1'b0, 64'h0,         3'd2};
    vecs[5]  = '{1'b0, 1'b1, 64'h8000_0008, 3'd2};
    vecs[6]  = '{1'b0, 1'b0, 64'h0,         3'd3};
    vecs[7]  = '{1'b0, 1'b1, 64'h8000_000C, 3'd3};
    vecs[8]  = '{1'b0, 1'b0, 64'h0,         3'd4};
    vecs[9]  = '{1'b0, 1'b0, 64'h0,         3'd4};
    vecs[10] = '{1'b0, 1'b0, 64'h0,         3'd4};
    vecs[11] = '{1'b1, 1'b0, 64'h0,         3'd4};
    vecs[12] = '{1'b0, 1'b1, 64'h8000_0010, 3'd3};
    vecs[13] = '{1'b0, 1'b0, 64'h0,         3'd4};
    vecs[14] = '{1'b0, 1'b0, 64'h0,         3'd4};

    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b0;
    force_stale    = 1'b0;
    iresp_addr_ok  = 1'b0;
    iresp_data_ok  = 1'b0;
    iresp_data     = '0;
    @(negedge clk);
    check_all_zero("reset");

    $display("[TB] fill and credit table");
    do_reset();
    for (int i = 0; i < 15; i++) begin
      out_ready = vecs[i].ready;
      check_output($sformatf("tbl%0d_occ", i), 64'(occupancy), 64'(vecs[i].exp_occ));
      check_output($sformatf("tbl%0d_ivalid", i), 64'(ireq_valid), 64'(vecs[i].exp_ivalid));
      if (vecs[i].exp_ivalid) check_output($sformatf("tbl%0d_addr", i), ireq_addr, vecs[i].exp_addr);
      apply_stimulus();
    end
    check_output("tbl_fetch_count", 64'(accept_count), 64'd5);

    $display("[TB] streaming with out_ready high");
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 24; k++) begin
      check_output($sformatf("stream%0d_occ", k), 64'(occupancy),
                   ((k >= 2) && (k % 2 == 0)) ? 64'd1 : 64'd0);
      apply_stimulus();
    end
    check_output("stream_pops", 64'(pops), 64'd11);

    $display("[TB] redirect during WAIT");
    do_reset();
    data_delay = 3;
    apply_stimulus();
    apply_stimulus();
    check_output("rw_in_wait", 64'(ireq_valid), 64'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_1002;
    apply_stimulus();
    redirect_valid = 1'b0;
    apply_stimulus();
    apply_stimulus();
    check_output("rw_occ_after_drop", 64'(occupancy), 64'd0);
    check_output("rw_valid_after_drop", 64'(out_valid), 64'd0);
    data_delay = 0;
    out_ready  = 1'b1;
    wait_accept("rw_next_addr", 64'h8000_1000);
    wait_pop("rw_first_pc", 64'h8000_1000);

    $display("[TB] redirect during REQ with addr_ok withheld");
    do_reset();
    addr_delay = 2;
    apply_stimulus();
    check_output("rq_c1_ivalid", 64'(ireq_valid), 64'd1);
    check_output("rq_c1_addr", ireq_addr, 64'h8000_0000);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_2000;
    apply_stimulus();
    redirect_valid = 1'b0;
    check_output("rq_c2_ivalid", 64'(ireq_valid), 64'd1);
    check_output("rq_c2_addr", ireq_addr, 64'h8000_0000);
    apply_stimulus();
    check_output("rq_c3_addr", ireq_addr, 64'h8000_0000);
    apply_stimulus();
    check_output("rq_accepts", 64'(accept_count), 64'd1);
    check_output("rq_occ_after_drop", 64'(occupancy), 64'd0);
    addr_delay = 0;
    wait_accept("rq_next_addr", 64'h8000_2000);
    out_ready = 1'b1;
    wait_pop("rq_first_pc", 64'h8000_2000);

    $display("[TB] redirect with same-cycle data_ok and pop");
    do_reset();
    for (int k = 0; k < 5; k++) apply_stimulus();
    check_output("rd_occ_before", 64'(occupancy), 64'd2);
    check_output("rd_ivalid_before", 64'(ireq_valid), 64'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_3000;
    out_ready      = 1'b1;
    apply_stimulus();
    redirect_valid = 1'b0;
    out_ready      = 1'b0;
    check_output("rd_occ_after", 64'(occupancy), 64'd0);
    check_output("rd_valid_after", 64'(out_valid), 64'd0);
    check_output("rd_pc_empty", out_pc, 64'd0);
    check_output("rd_instr_empty", 64'(out_instr), 64'd0);
    wait_accept("rd_next_addr", 64'h8000_3000);
    out_ready = 1'b1;
    wait_pop("rd_first_pc", 64'h8000_3000);

    $display("[TB] asynchronous reset during WAIT");
    do_reset();
    data_delay = 3;
    for (int k = 0; k < 7; k++) apply_stimulus();
    check_output("ar_occ_before", 64'(occupancy), 64'd1);
    check_output("ar_ivalid_before", 64'(ireq_valid), 64'd0);
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    bus_waiting = 1'b0;
    tb_drop     = 1'b0;
    addr_cnt    = 0;
    exp_q.delete();
    @(negedge clk);
    reset       = 1'b0;
    data_delay  = 0;
    force_stale = 1'b1;
    apply_stimulus();
    force_stale = 1'b0;
    check_output("ar_occ_after_stale", 64'(occupancy), 64'd0);
    check_output("ar_ivalid", 64'(ireq_valid), 64'd1);
    check_output("ar_first_addr", ireq_addr, RESET_PC);
    wait_accept("ar_accept_addr", RESET_PC);
    out_ready = 1'b1;
    wait_pop("ar_first_pc", RESET_PC);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
